// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the DIV/DIVU sequencer.
//   div_state_e  - sequencer states (idle, align, iterate, fix-up, done)
//   DIV_ZERO_LO  - quotient returned for a zero divisor (all ones), sliced to the datapath width
package div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StIter,
    StFixup,
    StDone
  } div_state_e;

  localparam int unsigned MaxWidth = 64;

  // Callers slice the low WIDTH bits.
  localparam logic [MaxWidth-1:0] DIV_ZERO_LO = {MaxWidth{1'b1}};

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes.
// Ports:
//   n      in   WIDTH  partial remainder
//   d      in   WIDTH  aligned divisor
//   n_next out  WIDTH  remainder after the conditional subtract
//   q_bit  out  1      quotient bit (1 when n >= d)
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] n_next,
  output logic             q_bit
);

  always_comb begin
    q_bit  = (n >= d);
    n_next = q_bit ? (n - d) : n;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer. Takes one request, aligns the divisor against the
// dividend one bit per cycle, runs shift-subtract iterations, applies the sign fix-up and returns
// the quotient on lo and the remainder on hi.
// Optional feature: define DIV_ZERO_FLAG_EN to add the div_zero output.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      request, sampled only when idle
//   flush      in   1      cancel the in-flight operation (wins over start when idle)
//   is_signed  in   1      1 = DIV, 0 = DIVU; latched with start
//   a          in   WIDTH  dividend; latched with start
//   b          in   WIDTH  divisor; latched with start
//   busy       out  1      high in every state except idle
//   done       out  1      one-cycle pulse; hi/lo valid from this cycle
//   hi         out  WIDTH  remainder, held until the next done
//   lo         out  WIDTH  quotient, held until the next done
//   div_zero   out  1      (DIV_ZERO_FLAG_EN only) pulses with done for a zero divisor
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] n_q, n_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0] d_q, d_d;     // divisor (magnitude), shifted during align/iterate
  logic [WIDTH-1:0] q_q, q_d;     // quotient magnitude
  logic [CNT_W-1:0] k_q, k_d;     // align shift count, counted back down while iterating
  logic             neg_q_q, neg_q_d;  // negate quotient on fix-up
  logic             neg_r_q, neg_r_d;  // negate remainder on fix-up
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] d_shl;
  logic [WIDTH-1:0] n_step;
  logic             q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .n      (n_q),
    .d      (d_q),
    .n_next (n_step),
    .q_bit  (q_bit)
  );

  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    d_shl = {d_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    q_d     = q_q;
    k_d     = k_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          n_d     = a_mag;
          d_d     = b_mag;
          q_d     = '0;
          k_d     = '0;
          neg_q_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = is_signed && a[WIDTH-1];
          if (b == '0) begin
            hi_d    = a;
            lo_d    = DIV_ZERO_LO[WIDTH-1:0];
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StAlign;
          end
        end
      end
      StAlign: begin
        // msb test keeps d<<1 from overflowing before the compare
        if (!d_q[WIDTH-1] && (d_shl <= n_q)) begin
          d_d = d_shl;
          k_d = k_q + 1'b1;
        end else begin
          state_d = StIter;
        end
      end
      StIter: begin
        n_d = n_step;
        q_d = {q_q[WIDTH-2:0], q_bit};
        d_d = d_q >> 1;
        if (k_q == '0) begin
          state_d = StFixup;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      StFixup: begin
        lo_d    = neg_q_q ? -q_q : q_q;
        hi_d    = neg_r_q ? -n_q : n_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A flush abandons the operation without touching the result registers.
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      q_q     <= q_d;
      k_q     <= k_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    hi   = hi_q;
    lo   = lo_q;
  end

`ifdef DIV_ZERO_FLAG_EN
  always_comb div_zero = dz_q && (state_q == StDone);
`else
  logic unused_dz;
  always_comb unused_dz = dz_q;
`endif

endmodule
